fft_bfly_sched: RTL

//  Memory-mapped openMSP430 peripheral that sequences the radix-2 DIT butterfly datapath of the N-point FFT.
//  The CPU writes START; the block walks every stage and butterfly, issuing operand/twiddle indices over valid/ready.
//  It waits for each butterfly to complete before issuing the next, then raises DONE and an optional interrupt.
//  It sits on the peripheral bus beside gpio/timerA/uart/transpose; its per_dout is OR-ed into the CPU per_dout.

---
 rtl/fft_bfly_sched.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/fft_bfly_sched.sv
// Radix-2 DIT butterfly sequencer for an N-point FFT, exposed as an openMSP430 peripheral.
// Walks every stage/butterfly, issuing operand and twiddle indices over valid/ready.
module fft_bfly_sched #(
  parameter logic [14:0] BASE_ADDR = 15'h0190,
  parameter int unsigned N_LOG2    = 4
) (
  input  logic              mclk,
  input  logic              puc_rst,
  input  logic [13:0]       per_addr,
  input  logic [15:0]       per_din,
  input  logic              per_en,
  input  logic [1:0]        per_we,
  output logic [15:0]       per_dout,
  output logic              bf_valid,
  input  logic              bf_ready,
  output logic [N_LOG2-1:0] bf_addr_a,
  output logic [N_LOG2-1:0] bf_addr_b,
  output logic [N_LOG2-2:0] bf_tw,
  output logic [2:0]        bf_stage,
  input  logic              bf_done,
  output logic              irq_fft
);

  localparam int unsigned       KW        = N_LOG2 - 1;
  localparam logic [2:0]        LastStage = 3'(N_LOG2 - 1);
  localparam logic [KW-1:0]     KMax      = '1;
  localparam logic [N_LOG2-1:0] One       = 1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e          state_q, state_d;
  logic [2:0]      stage_q, stage_d;
  logic [KW-1:0]   k_q, k_d;
  logic [15:0]     count_q, count_d;
  logic            ie_q, ie_d, done_q, done_d, err_q, err_d;

  logic            sel, wr, rd, wr_ctrl, wr_status, start, abort, busy;
  logic [1:0]      reg_sel;
  logic            last_k, last_stage, bf_fire;
  logic            unused_din;

  assign sel       = per_en & (per_addr[13:2] == BASE_ADDR[14:3]);
  assign reg_sel   = per_addr[1:0];
  assign wr        = sel & (|per_we);
  assign rd        = sel & (per_we == 2'b00);
  assign wr_ctrl   = wr & (reg_sel == 2'd0);
  assign wr_status = wr & (reg_sel == 2'd1);
  assign start     = wr_ctrl & per_din[0];
  assign abort     = wr_ctrl & per_din[2];
  assign unused_din = ^per_din[15:3];

  assign last_k     = (k_q == KMax);
  assign last_stage = (stage_q == LastStage);
  assign bf_fire    = (state_q == StWait) & bf_done;

  // State register
  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      state_q <= StIdle;
      stage_q <= '0;
      k_q     <= '0;
      count_q <= '0;
      ie_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      k_q     <= k_d;
      count_q <= count_d;
      ie_q    <= ie_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next-state: FSM
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:  if (start) state_d = StIssue;
        StIssue: if (bf_ready) state_d = StWait;
        StWait:  if (bf_done) state_d = (last_k && last_stage) ? StIdle : StIssue;
        default: state_d = StIdle;
      endcase
    end
  end

  // Next-state: counters and status; sets are applied after W1C so a set wins
  always_comb begin
    stage_d = stage_q;
    k_d     = k_q;
    count_d = count_q;
    ie_d    = wr_ctrl ? per_din[1] : ie_q;
    done_d  = done_q;
    err_d   = err_q;
    if (wr_status) begin
      done_d = done_q & ~per_din[1];
      err_d  = err_q & ~per_din[2];
    end
    if (!abort && state_q == StIdle && start) begin
      stage_d = '0;
      k_d     = '0;
      count_d = '0;
      done_d  = 1'b0;
      err_d   = 1'b0;
    end
    if (bf_done && state_q != StWait) err_d = 1'b1;
    if (!abort && bf_fire) begin
      count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
      if (last_k) begin
        if (last_stage) begin
          done_d = 1'b1;
        end else begin
          k_d     = '0;
          stage_d = stage_q + 3'd1;
        end
      end else begin
        k_d = k_q + 1'b1;
      end
    end
  end

  // Outputs: index math is only exported while sequencing so idle outputs read as zero
  logic [N_LOG2-1:0] k_ext, span, a_idx, tw_full;
  always_comb begin
    k_ext   = N_LOG2'(k_q);
    span    = One << stage_q;
    a_idx   = ((k_ext >> stage_q) << (stage_q + 3'd1)) | (k_ext & (span - One));
    tw_full = (k_ext & (span - One)) << (LastStage - stage_q);
    busy      = (state_q != StIdle);
    bf_valid  = (state_q == StIssue);
    bf_addr_a = '0;
    bf_addr_b = '0;
    bf_tw     = '0;
    bf_stage  = '0;
    if (busy) begin
      bf_addr_a = a_idx;
      bf_addr_b = a_idx + span;
      bf_tw     = tw_full[N_LOG2-2:0];
      bf_stage  = stage_q;
    end
    irq_fft = done_q & ie_q;
  end

  always_comb begin
    per_dout = '0;
    if (rd) begin
      unique case (reg_sel)
        2'd0: per_dout = {13'b0, 1'b0, ie_q, 1'b0};
        2'd1: per_dout = {13'b0, err_q, done_q, busy};
        2'd2: per_dout = {5'b0, stage_q, 2'b0, 6'(k_q)};
        2'd3: per_dout = count_q;
        default: per_dout = '0;
      endcase
    end
  end

endmodule
